// File: rtl/rr_axi_sel_ctrl.sv
// Record/replay AXI selector sequencer: flips sel only when the bus is idle.
// Quiesces upstream, drains in-flight bursts, switches, then settles.
module rr_axi_sel_ctrl #(
  parameter int CNT_WIDTH      = 8,
  parameter int SETTLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_sel,
  input  logic awvalid,
  input  logic awready,
  input  logic wvalid,
  input  logic wready,
  input  logic wlast,
  input  logic bvalid,
  input  logic bready,
  input  logic arvalid,
  input  logic arready,
  input  logic rvalid,
  input  logic rready,
  input  logic rlast,
  output logic sel,
  output logic quiesce,
  output logic busy,
  output logic switch_done,
  output logic drain_timeout,
  output logic cnt_err
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DRAIN  = 2'd1;
  localparam logic [1:0] S_SWITCH = 2'd2;
  localparam logic [1:0] S_SETTLE = 2'd3;

  localparam int SW = (SETTLE_CYCLES > 1) ?
    $clog2(SETTLE_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ?
    $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [SW-1:0] S_LAST =
    SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] T_LAST =
    TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [SW-1:0] S_ONE = SW'(1);
  localparam logic [TW-1:0] T_ONE = TW'(1);

  localparam logic [CNT_WIDTH-1:0] C_ONE = CNT_WIDTH'(1);
  localparam logic signed [CNT_WIDTH:0] P_ONE =
    (CNT_WIDTH+1)'(1);
  localparam logic signed [CNT_WIDTH:0] P_MAX =
    {1'b0, {CNT_WIDTH{1'b1}}};
  localparam logic signed [CNT_WIDTH:0] P_MIN =
    {1'b1, {CNT_WIDTH{1'b0}}};

  logic [1:0]                  state;
  logic [CNT_WIDTH-1:0]        wr_out, wr_nxt;
  logic [CNT_WIDTH-1:0]        rd_out, rd_nxt;
  logic signed [CNT_WIDTH:0]   w_pend, wp_nxt;
  logic                        wr_e, rd_e, wp_e;
  logic [TW-1:0]               tcnt;
  logic [SW-1:0]               scnt;
  logic                        aw_hs, wl_hs, b_hs;
  logic                        ar_hs, rl_hs;
  logic                        quiescent;

  assign aw_hs = awvalid & awready;
  assign wl_hs = wvalid & wready & wlast;
  assign b_hs  = bvalid & bready;
  assign ar_hs = arvalid & arready;
  assign rl_hs = rvalid & rready & rlast;

  assign quiescent = (wr_out == '0) && (w_pend == '0) &&
                     (rd_out == '0) && !awvalid &&
                     !arvalid && !wvalid;

  assign busy = (state != S_IDLE);

  // Counters saturate instead of wrapping; the error stays sticky.
  always_comb begin
    wr_nxt = wr_out;
    wr_e   = 1'b0;
    if (aw_hs && !b_hs) begin
      if (&wr_out) wr_e = 1'b1;
      else wr_nxt = wr_out + C_ONE;
    end else if (!aw_hs && b_hs) begin
      if (wr_out == '0) wr_e = 1'b1;
      else wr_nxt = wr_out - C_ONE;
    end
  end

  always_comb begin
    rd_nxt = rd_out;
    rd_e   = 1'b0;
    if (ar_hs && !rl_hs) begin
      if (&rd_out) rd_e = 1'b1;
      else rd_nxt = rd_out + C_ONE;
    end else if (!ar_hs && rl_hs) begin
      if (rd_out == '0) rd_e = 1'b1;
      else rd_nxt = rd_out - C_ONE;
    end
  end

  // W may lead AW, so this one runs negative.
  always_comb begin
    wp_nxt = w_pend;
    wp_e   = 1'b0;
    if (aw_hs && !wl_hs) begin
      if (w_pend == P_MAX) wp_e = 1'b1;
      else wp_nxt = w_pend + P_ONE;
    end else if (!aw_hs && wl_hs) begin
      if (w_pend == P_MIN) wp_e = 1'b1;
      else wp_nxt = w_pend - P_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_out  <= '0;
      rd_out  <= '0;
      w_pend  <= '0;
      cnt_err <= 1'b0;
    end else begin
      wr_out <= wr_nxt;
      rd_out <= rd_nxt;
      w_pend <= wp_nxt;
      if (wr_e || rd_e || wp_e) cnt_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      sel           <= 1'b0;
      quiesce       <= 1'b0;
      switch_done   <= 1'b0;
      drain_timeout <= 1'b0;
      tcnt          <= '0;
      scnt          <= '0;
    end else begin
      switch_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_sel != sel) begin
            state   <= S_DRAIN;
            quiesce <= 1'b1;
            tcnt    <= '0;
          end
        end
        S_DRAIN: begin
          if (TIMEOUT_CYCLES != 0 && tcnt == T_LAST)
            drain_timeout <= 1'b1;
          if (!(&tcnt)) tcnt <= tcnt + T_ONE;
          if (req_sel == sel) begin
            state   <= S_IDLE;
            quiesce <= 1'b0;
          end else if (quiescent) begin
            state <= S_SWITCH;
          end
        end
        S_SWITCH: begin
          sel   <= ~sel;
          scnt  <= '0;
          state <= S_SETTLE;
        end
        S_SETTLE: begin
          if (scnt == S_LAST) begin
            state       <= S_IDLE;
            quiesce     <= 1'b0;
            switch_done <= 1'b1;
          end else begin
            scnt <= scnt + S_ONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_axi_sel_ctrl.sv
// Bench for rr_axi_sel_ctrl: cycle vectors with hand-derived expectations.
// Expected outputs go through a queue between drive and sample.
module tb_rr_axi_sel_ctrl;

  logic clk, rst_n, req_sel;
  logic awvalid, awready, wvalid, wready, wlast;
  logic bvalid, bready, arvalid, arready;
  logic rvalid, rready, rlast;
  logic sel, quiesce, busy, switch_done;
  logic drain_timeout, cnt_err;

  int tests = 0;
  int fails = 0;

  logic [5:0] exp_q[$];

  typedef struct {
    logic [7:0] in;
    logic [5:0] exp;
  } vec_t;

  vec_t tbl[12];

  rr_axi_sel_ctrl #(
    .CNT_WIDTH(8),
    .SETTLE_CYCLES(2),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_sel(req_sel),
    .awvalid(awvalid),
    .awready(awready),
    .wvalid(wvalid),
    .wready(wready),
    .wlast(wlast),
    .bvalid(bvalid),
    .bready(bready),
    .arvalid(arvalid),
    .arready(arready),
    .rvalid(rvalid),
    .rready(rready),
    .rlast(rlast),
    .sel(sel),
    .quiesce(quiesce),
    .busy(busy),
    .switch_done(switch_done),
    .drain_timeout(drain_timeout),
    .cnt_err(cnt_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // in: req aw w wlast b ar r rlast
  localparam logic [7:0] REQ  = 8'h80;
  localparam logic [7:0] AW   = 8'h40;
  localparam logic [7:0] WL   = 8'h30;
  localparam logic [7:0] B    = 8'h08;
  localparam logic [7:0] AR   = 8'h04;
  localparam logic [7:0] RL   = 8'h03;
  localparam logic [7:0] NONE = 8'h00;

  // exp: sel quiesce busy done timeout err
  localparam logic [5:0] I0  = 6'b000000;
  localparam logic [5:0] I1  = 6'b100000;
  localparam logic [5:0] Q0  = 6'b011000;
  localparam logic [5:0] Q1  = 6'b111000;
  localparam logic [5:0] D0  = 6'b000100;
  localparam logic [5:0] D1  = 6'b100100;

  function automatic logic [5:0] outs();
    return {sel, quiesce, busy, switch_done,
            drain_timeout, cnt_err};
  endfunction

  task automatic check(input string name,
                       input logic [5:0] act,
                       input logic [5:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b",
               name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] in);
    req_sel = in[7];
    awvalid = in[6]; awready = in[6];
    wvalid  = in[5]; wready  = in[5];
    wlast   = in[4];
    bvalid  = in[3]; bready  = in[3];
    arvalid = in[2]; arready = in[2];
    rvalid  = in[1]; rready  = in[1];
    rlast   = in[0];
  endtask

  task automatic run(input logic [7:0] in,
                     input logic [5:0] exp,
                     input string name);
    logic [5:0] e;
    @(negedge clk);
    drive(in);
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = exp_q.pop_front();
      check(name, outs(), e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{REQ, Q0};
    tbl[1]  = '{REQ, Q0};
    tbl[2]  = '{REQ, Q1};
    tbl[3]  = '{REQ, Q1};
    tbl[4]  = '{REQ, D1};
    tbl[5]  = '{REQ, I1};
    tbl[6]  = '{NONE, Q1};
    tbl[7]  = '{NONE, Q1};
    tbl[8]  = '{NONE, Q0};
    tbl[9]  = '{NONE, Q0};
    tbl[10] = '{NONE, D0};
    tbl[11] = '{NONE, I0};

    rst_n = 1'b0;
    drive(NONE);
    #1;
    check("reset", outs(), I0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run(NONE, I0, "idle_after_reset");

    for (int i = 0; i < 12; i++)
      run(tbl[i].in, tbl[i].exp, $sformatf("idle_sw[%0d]", i));

    // three writes and three reads outstanding
    repeat (3) run(AW | WL | AR, I0, "issue");
    repeat (3) run(REQ, Q0, "drain_wait");
    repeat (3) run(REQ | B, Q0, "drain_b");
    repeat (3) run(REQ | RL, Q0, "drain_r");
    run(REQ, Q0, "drain_switch");
    run(REQ, Q1, "drain_settle0");
    run(REQ, Q1, "drain_settle1");
    run(REQ, D1, "drain_done");
    run(REQ, I1, "drain_idle");

    // W leads AW: switch must wait for the AW
    run(REQ | WL, I1, "wlead_w");
    repeat (3) run(NONE, Q1, "wlead_wait");
    run(AW, Q1, "wlead_aw");
    run(B, Q1, "wlead_b");
    run(NONE, Q1, "wlead_switch");
    run(NONE, Q0, "wlead_settle0");
    run(NONE, Q0, "wlead_settle1");
    run(NONE, D0, "wlead_done");
    run(NONE, I0, "wlead_idle");

    // request withdrawn during DRAIN
    run(AW | WL, I0, "wd_aw");
    repeat (3) run(REQ, Q0, "wd_drain");
    run(NONE, I0, "wd_back_idle");
    run(B, I0, "wd_b");
    run(NONE, I0, "wd_quiet");

    // drain timeout, then late B completes the switch
    run(AW | WL, I0, "to_aw");
    repeat (16) run(REQ, Q0, "to_drain");
    run(REQ, 6'b011010, "to_flag");
    run(REQ | B, 6'b011010, "to_b");
    run(REQ, 6'b011010, "to_switch");
    run(REQ, 6'b111010, "to_settle0");
    run(REQ, 6'b111010, "to_settle1");
    run(REQ, 6'b100110, "to_done");
    run(REQ, 6'b100010, "to_idle");

    // B with nothing outstanding; counter must stay at 0
    run(REQ | B, 6'b100011, "err_b");
    run(NONE, 6'b111011, "err_drain");
    run(NONE, 6'b111011, "err_switch");
    run(NONE, 6'b011011, "err_settle0");
    run(NONE, 6'b011011, "err_settle1");
    run(NONE, 6'b000111, "err_done");
    run(NONE, 6'b000011, "err_idle");

    // async reset while settling with sel=1
    run(REQ, 6'b011011, "rst_drain");
    run(REQ, 6'b011011, "rst_switch");
    run(REQ, 6'b111011, "rst_settle");
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async", outs(), I0);
    @(negedge clk);
    drive(NONE);
    @(posedge clk);
    #1;
    check("rst_held", outs(), I0);
    @(negedge clk);
    rst_n = 1'b1;
    run(NONE, I0, "rst_release0");
    run(NONE, I0, "rst_release1");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rr_axi_sel_ctrl.md
Name: rr_axi_sel_ctrl

Overview:
- Sequences the select input of an AXI master-side two-way bus selector (record/replay path switch).
- Changes sel only when the selected AXI bus is quiescent: no outstanding AW/W/B or AR/R traffic.
- While a switch is pending it tells the active upstream master to stop issuing new addresses, drains in-flight bursts, flips sel, then waits a settle window.
- Sits between the CSR block (requested select) and the selector's sel pin; monitors the selector's output-side AXI handshakes.

Parameters:
- CNT_WIDTH, 8, width of each outstanding-transaction counter.
- SETTLE_CYCLES, 2, cycles held in SETTLE after sel flips (≥1).
- TIMEOUT_CYCLES, 4096, max DRAIN cycles before timeout flag; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_sel  in  1  requested select from CSR, level.
- awvalid, awready  in  1 each  AW handshake on the selector output side.
- wvalid, wready, wlast  in  1 each  W handshake.
- bvalid, bready  in  1 each  B handshake.
- arvalid, arready  in  1 each  AR handshake.
- rvalid, rready, rlast  in  1 each  R handshake.
- sel  out  1  drives the selector (0=A, 1=B).
- quiesce  out  1  upstream must not assert new awvalid/arvalid while high.
- busy  out  1  high in any state other than IDLE.
- switch_done  out  1  one-cycle pulse on SETTLE->IDLE.
- drain_timeout  out  1  sticky; cleared only by reset.
- cnt_err  out  1  sticky counter overflow/underflow; cleared only by reset.

Behaviour:
- Reset (async assert, sync deassert assumed upstream): sel=0, quiesce=0, busy=0, switch_done=0, drain_timeout=0, cnt_err=0, all counters 0, state IDLE.
- Counters update every cycle regardless of state. Handshake means valid&&ready.
  - wr_out: +1 on AW handshake, -1 on B handshake.
  - w_pend (signed, CNT_WIDTH+1 bits): +1 on AW handshake, -1 on W handshake with wlast. A negative value is legal (W leads AW).
  - rd_out: +1 on AR handshake, -1 on R handshake with rlast.
  - Simultaneous increment and decrement leaves the counter unchanged.
  - Unsigned counters at max with increment only: hold, set cnt_err. At 0 with decrement only: hold, set cnt_err.
- quiescent = wr_out==0 && w_pend==0 && rd_out==0 && !awvalid && !arvalid && !wvalid.
- FSM:
  - IDLE: if req_sel!=sel, go to DRAIN and assert quiesce the next cycle (registered). Otherwise stay.
  - DRAIN: quiesce=1 and the timeout counter increments.
    - If req_sel==sel (request withdrawn): go back to IDLE, quiesce=0, no sel change, no switch_done.
    - Else if quiescent: go to SWITCH.
    - If the timeout counter reaches TIMEOUT_CYCLES (TIMEOUT_CYCLES≠0): set drain_timeout and keep waiting. Never force a switch.
  - SWITCH: one cycle. sel<=~sel, quiesce stays 1, go to SETTLE.
  - SETTLE: quiesce=1 for SETTLE_CYCLES cycles, then go to IDLE with quiesce=0 and switch_done pulsed for 1 cycle. A req_sel change during SETTLE is serviced from IDLE next.
- Latency with no traffic: req_sel toggle at cycle 0 gives DRAIN at 1, SWITCH at 2, sel flipped at 3, switch_done at 3+SETTLE_CYCLES.
- sel never changes outside SWITCH.
- Reset asserted mid-operation: everything returns to reset values immediately, sel=0 even if it was 1.

Test Plan:
- Idle bus: req_sel 0->1 at cycle 0 -> sel=1 at cycle 3; switch_done pulses at cycle 5 (SETTLE_CYCLES=2); quiesce high cycles 1-4.
- 3 AW handshakes and 3 AR handshakes, then req_sel=1 -> sel stays 0 until the 3rd B and 3rd R-with-rlast handshakes; sel flips 2 cycles after the last completion.
- W burst completes before its AW (w_pend=-1), then AW handshake -> w_pend returns to 0; a switch requested in between waits for the AW.
- In DRAIN with 1 write outstanding, req_sel returns to 0 -> IDLE next cycle; quiesce drops; sel and switch_done unchanged.
- TIMEOUT_CYCLES=16, B never returned -> drain_timeout=1 after 16 DRAIN cycles; sel still 0; the later B completes the switch normally.
- B handshake with wr_out=0 -> cnt_err=1, counter stays 0. Reset asserted while in SETTLE with sel=1 -> sel=0, all flags 0.
